// File: rtl/dma_pkg.sv
// ============================================================================
// Module      : dma_pkg
// Description : Shared types and constants for the DMA AXI4 read engine.
//               Holds the read FSM state encoding, AXI burst/response
//               constants and the ARSIZE helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dma_pkg;

   // Read engine FSM states (explicit 3-bit encoding).
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_NEXT = 3'd3,
      ST_DONE = 3'd4
   } dma_rd_state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // ARSIZE encoding: log2 of bytes per beat.
   function automatic logic [2:0] axi_size(input int data_width);
      return 3'($clog2(data_width / 8));
   endfunction

endpackage

`default_nettype wire

// File: rtl/axi_dma_rd_engine_if.sv
// ============================================================================
// Module      : axi_dma_rd_engine_if
// Description : AXI4 read address / read data channel bundle.
//               master modport : the DMA read engine (drives AR, R ready)
//               slave  modport : the AXI memory side (drives AR ready, R)
// Parameters  : AXI_WIDTH_AD - address width, AXI_WIDTH_DA - data width
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_dma_rd_engine_if #(
   parameter int AXI_WIDTH_AD = 32,
   parameter int AXI_WIDTH_DA = 32
) ();

   logic [AXI_WIDTH_AD-1:0] m_axi_araddr;
   logic [7:0]              m_axi_arlen;
   logic [2:0]              m_axi_arsize;
   logic [1:0]              m_axi_arburst;
   logic                    m_axi_arvalid;
   logic                    m_axi_arready;
   logic [AXI_WIDTH_DA-1:0] m_axi_rdata;
   logic [1:0]              m_axi_rresp;
   logic                    m_axi_rlast;
   logic                    m_axi_rvalid;
   logic                    m_axi_rready;

   modport master (
      output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
             m_axi_arvalid, m_axi_rready,
      input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast,
             m_axi_rvalid
   );

   modport slave (
      input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
             m_axi_arvalid, m_axi_rready,
      output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast,
             m_axi_rvalid
   );

endinterface

`default_nettype wire

// File: rtl/axi_burst_calc.sv
// ============================================================================
// Module      : axi_burst_calc
// Description : Combinational burst sizing. From the beats still to read and
//               the current burst address, produces the beat count of the
//               next burst (clipped to MAX_BURST_LEN), its ARLEN, and the
//               address that follows the burst (wraps at AXI_WIDTH_AD).
// Ports       : i_remaining, i_addr -> o_arlen, o_burst_beats, o_next_addr
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_burst_calc #(
   parameter int AXI_WIDTH_AD  = 32,
   parameter int AXI_WIDTH_DA  = 32,
   parameter int BIT_TRANS     = 18,
   parameter int MAX_BURST_LEN = 16,
   parameter int CNT_W         = $clog2(MAX_BURST_LEN) + 1
) (
   input  logic [BIT_TRANS-1:0]    i_remaining,
   input  logic [AXI_WIDTH_AD-1:0] i_addr,
   output logic [7:0]              o_arlen,
   output logic [CNT_W-1:0]        o_burst_beats,
   output logic [AXI_WIDTH_AD-1:0] o_next_addr
);

   localparam logic [BIT_TRANS-1:0]    c_max_len = BIT_TRANS'(MAX_BURST_LEN);
   localparam logic [AXI_WIDTH_AD-1:0] c_bytes   = AXI_WIDTH_AD'(AXI_WIDTH_DA / 8);

   logic w_clip;

   assign w_clip        = (i_remaining > c_max_len);
   assign o_burst_beats = w_clip ? CNT_W'(MAX_BURST_LEN) : i_remaining[CNT_W-1:0];
   assign o_arlen       = 8'(o_burst_beats - CNT_W'(1));
   assign o_next_addr   = i_addr + (AXI_WIDTH_AD'(o_burst_beats) * c_bytes);

endmodule

`default_nettype wire

// File: rtl/axi_dma_rd_engine.sv
// ============================================================================
// Module      : axi_dma_rd_engine
// Description : AXI4 read master for the DMA. Takes a one-cycle read command
//               (address + beat count), splits it into INCR bursts of at most
//               MAX_BURST_LEN beats with one AR outstanding at a time, and
//               passes R beats straight through to the buffer stream
//               (m_axi_rready follows i_rd_ready). Pulses o_read_done after
//               the last beat.
// Ports       : clk, rst (sync, active-high)
//               i_ctrl_read, i_read_addr, i_num_trans  - command
//               o_busy, o_read_done                    - status
//               o_rd_data, o_rd_valid, i_rd_ready      - output stream
//               m_axi (axi_dma_rd_engine_if.master)    - AXI AR/R channels
// Options     : DMA_RD_ERR_CHK_EN - adds o_rd_err[1:0]: bit0 sticky on a
//               non-OKAY rresp, bit1 sticky on an rlast/burst-count mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_dma_rd_engine
   import dma_pkg::*;
#(
   parameter int AXI_WIDTH_AD  = 32,
   parameter int AXI_WIDTH_DA  = 32,
   parameter int BIT_TRANS     = 18,
   parameter int MAX_BURST_LEN = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_ctrl_read,
   input  logic [AXI_WIDTH_AD-1:0] i_read_addr,
   input  logic [BIT_TRANS-1:0]    i_num_trans,
   output logic                    o_busy,
   output logic                    o_read_done,
   output logic [AXI_WIDTH_DA-1:0] o_rd_data,
   output logic                    o_rd_valid,
   input  logic                    i_rd_ready,
`ifdef DMA_RD_ERR_CHK_EN
   output logic [1:0]              o_rd_err,
`endif
   axi_dma_rd_engine_if.master     m_axi
);

   localparam int CNT_W = $clog2(MAX_BURST_LEN) + 1;

   dma_rd_state_t           r_state, w_next_state;
   logic [AXI_WIDTH_AD-1:0] r_addr, r_next_addr, w_next_addr;
   logic [BIT_TRANS-1:0]    r_remaining;
   logic [CNT_W-1:0]        r_burst_cnt, w_burst_beats;
   logic [7:0]              w_arlen;
   logic                    w_ar_hs, w_r_hs, w_last_beat;
   logic                    w_arvalid, w_rready;

   axi_burst_calc #(
      .AXI_WIDTH_AD  (AXI_WIDTH_AD),
      .AXI_WIDTH_DA  (AXI_WIDTH_DA),
      .BIT_TRANS     (BIT_TRANS),
      .MAX_BURST_LEN (MAX_BURST_LEN),
      .CNT_W         (CNT_W)
   ) u_burst_calc (
      .i_remaining   (r_remaining),
      .i_addr        (r_addr),
      .o_arlen       (w_arlen),
      .o_burst_beats (w_burst_beats),
      .o_next_addr   (w_next_addr)
   );

   assign w_ar_hs     = (r_state == ST_AR) && m_axi.m_axi_arready;
   assign w_r_hs      = (r_state == ST_R) && m_axi.m_axi_rvalid && i_rd_ready;
   // The local burst counter, not rlast, decides where a burst ends.
   assign w_last_beat = w_r_hs && (r_burst_cnt == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_next_addr <= '0;
         r_remaining <= '0;
         r_burst_cnt <= '0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            ST_IDLE: begin
               if (i_ctrl_read) begin
                  r_addr      <= i_read_addr;
                  r_remaining <= i_num_trans;
               end
            end
            ST_AR: begin
               // ARLEN/ARADDR come from r_remaining/r_addr, which hold still
               // here, so AR stays stable until accepted.
               if (w_ar_hs) begin
                  r_burst_cnt <= w_burst_beats;
                  r_next_addr <= w_next_addr;
               end
            end
            ST_R: begin
               if (w_r_hs) begin
                  r_remaining <= r_remaining - BIT_TRANS'(1);
                  r_burst_cnt <= r_burst_cnt - CNT_W'(1);
               end
            end
            ST_NEXT: r_addr <= r_next_addr;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next_state = r_state;
      o_busy       = (r_state != ST_IDLE);
      o_read_done  = 1'b0;
      o_rd_valid   = 1'b0;
      o_rd_data    = '0;
      w_arvalid    = 1'b0;
      w_rready     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_ctrl_read)
               w_next_state = (i_num_trans != '0) ? ST_AR : ST_DONE;
         end
         ST_AR: begin
            w_arvalid = 1'b1;
            if (m_axi.m_axi_arready) w_next_state = ST_R;
         end
         ST_R: begin
            w_rready   = i_rd_ready;
            o_rd_valid = m_axi.m_axi_rvalid;
            o_rd_data  = m_axi.m_axi_rdata;
            if (w_last_beat) w_next_state = ST_NEXT;
         end
         ST_NEXT: begin
            w_next_state = (r_remaining != '0) ? ST_AR : ST_DONE;
         end
         ST_DONE: begin
            o_read_done  = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   assign m_axi.m_axi_araddr  = r_addr;
   assign m_axi.m_axi_arlen   = w_arvalid ? w_arlen : 8'd0;
   assign m_axi.m_axi_arsize  = axi_size(AXI_WIDTH_DA);
   assign m_axi.m_axi_arburst = AXI_BURST_INCR;
   assign m_axi.m_axi_arvalid = w_arvalid;
   assign m_axi.m_axi_rready  = w_rready;

`ifdef DMA_RD_ERR_CHK_EN
   logic [1:0] r_rd_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_err <= '0;
      end else if ((r_state == ST_IDLE) && i_ctrl_read) begin
         r_rd_err <= '0;
      end else if (w_r_hs) begin
         if (m_axi.m_axi_rresp != AXI_RESP_OKAY)
            r_rd_err[0] <= 1'b1;
         if (m_axi.m_axi_rlast != (r_burst_cnt == CNT_W'(1)))
            r_rd_err[1] <= 1'b1;
      end
   end

   assign o_rd_err = r_rd_err;
`else
   logic w_unused_rsp;
   assign w_unused_rsp = ^{m_axi.m_axi_rresp, m_axi.m_axi_rlast};
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_dma_rd_engine.sv
// ============================================================================
// Module      : tb_axi_dma_rd_engine
// Description : Self-checking bench for axi_dma_rd_engine. A behavioural AXI
//               slave returns data that is a fixed function of the beat
//               address; expected AR lists and beat streams are derived from
//               the command alone. Table vectors, random commands and
//               hand-written reset / zero-length / strobe-timing sequences.
//               Honours DMA_RD_ERR_CHK_EN for the error-flag sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_dma_rd_engine;
   import dma_pkg::*;

   localparam int AD = 32, DA = 32, BT = 18, MBL = 16, BYTES = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_ctrl_read;
   logic [AD-1:0] i_read_addr;
   logic [BT-1:0] i_num_trans;
   logic          o_busy, o_read_done, o_rd_valid, i_rd_ready;
   logic [DA-1:0] o_rd_data;
`ifdef DMA_RD_ERR_CHK_EN
   logic [1:0]    o_rd_err;
`endif

   always #5 clk = ~clk;

   axi_dma_rd_engine_if #(.AXI_WIDTH_AD(AD), .AXI_WIDTH_DA(DA)) axi ();

   axi_dma_rd_engine #(
      .AXI_WIDTH_AD(AD), .AXI_WIDTH_DA(DA), .BIT_TRANS(BT), .MAX_BURST_LEN(MBL)
   ) dut (
      .clk(clk), .rst(rst), .i_ctrl_read(i_ctrl_read), .i_read_addr(i_read_addr),
      .i_num_trans(i_num_trans), .o_busy(o_busy), .o_read_done(o_read_done),
      .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
`ifdef DMA_RD_ERR_CHK_EN
      .o_rd_err(o_rd_err),
`endif
      .m_axi(axi)
   );

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Slave data pattern: a fixed function of the byte address of the beat.
   function automatic logic [31:0] dfun(input logic [31:0] a);
      return (a * 32'd2654435761) ^ 32'h5A5A_1234;
   endfunction

   typedef struct { logic [31:0] addr; int len; } burst_t;
   burst_t        s_q[$];
   int            s_beat;
   bit            s_hold;
   logic [31:0]   ar_addr_obs[$];
   int            ar_len_obs[$];
   logic [31:0]   data_obs[$];
   int            cyc = 0, done_cnt, done_cyc, last_hs_cyc, arv_first_cyc, viol, hs_total;
   int            rdy_mode = 0, gap_pct = 0, cur_n, strobe_cyc = -1;
   bit            arrdy_rand = 0, strobe_at_done = 0, cmd_go = 0;
   logic [31:0]   cmd_addr;
   logic [BT-1:0] cmd_n;
   bit            prev_ar_stall;
   logic [31:0]   prev_araddr;
   logic [7:0]    prev_arlen;
   int            inj_resp_beat = -1, inj_last_beat = -1;

   task automatic slave_reset();
      s_q.delete();
      s_beat = 0; s_hold = 0; prev_ar_stall = 0;
      axi.m_axi_rvalid = 1'b0;
   endtask

   task automatic clear_obs();
      ar_addr_obs.delete(); ar_len_obs.delete(); data_obs.delete();
      done_cnt = 0; done_cyc = -1; last_hs_cyc = -1; arv_first_cyc = -1;
      viol = 0; hs_total = 0;
   endtask

   // One clock: drive all inputs after the falling edge, sample 1 ns later,
   // and account for the handshakes that the next rising edge will complete.
   task automatic step();
      @(negedge clk);
      cyc++;
      i_ctrl_read = cmd_go || (cyc == strobe_cyc);
      if (cmd_go) begin
         i_read_addr = cmd_addr; i_num_trans = cmd_n;
      end else if (cyc == strobe_cyc) begin
         i_read_addr = 32'h7777_0000; i_num_trans = 18'd5;
      end
      cmd_go = 0;
      axi.m_axi_arready = arrdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!s_hold) begin
         if (s_q.size() != 0 && $urandom_range(0, 99) >= gap_pct) begin
            axi.m_axi_rvalid = 1'b1;
            axi.m_axi_rdata  = dfun(s_q[0].addr + BYTES * s_beat);
            axi.m_axi_rlast  = (s_beat == s_q[0].len - 1) || (s_beat == inj_last_beat);
            axi.m_axi_rresp  = (s_beat == inj_resp_beat) ? 2'b10 : AXI_RESP_OKAY;
         end else begin
            axi.m_axi_rvalid = 1'b0;
            axi.m_axi_rdata  = $urandom;
            axi.m_axi_rlast  = 1'b0;
            axi.m_axi_rresp  = AXI_RESP_OKAY;
         end
      end
      case (rdy_mode)
         0:       i_rd_ready = 1'b1;
         1:       i_rd_ready = (cyc % 2 == 0);
         default: i_rd_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (axi.m_axi_arvalid) begin
         if (arv_first_cyc < 0) arv_first_cyc = cyc;
         if (prev_ar_stall && (axi.m_axi_araddr !== prev_araddr || axi.m_axi_arlen !== prev_arlen)) viol++;
         if (axi.m_axi_arsize !== 3'd2 || axi.m_axi_arburst !== 2'b01) viol++;
         if (axi.m_axi_arready) begin
            ar_addr_obs.push_back(axi.m_axi_araddr);
            ar_len_obs.push_back(int'(axi.m_axi_arlen));
            s_q.push_back('{axi.m_axi_araddr, int'(axi.m_axi_arlen) + 1});
         end
      end else if (prev_ar_stall) viol++;
      prev_ar_stall = axi.m_axi_arvalid && !axi.m_axi_arready;
      prev_araddr   = axi.m_axi_araddr;
      prev_arlen    = axi.m_axi_arlen;
      if (axi.m_axi_rready && !i_rd_ready) viol++;
      if (o_rd_valid && (!axi.m_axi_rvalid || o_rd_data !== axi.m_axi_rdata || axi.m_axi_rready !== i_rd_ready)) viol++;
      if (axi.m_axi_rvalid && axi.m_axi_rready && !o_rd_valid) viol++;
      s_hold = axi.m_axi_rvalid && !axi.m_axi_rready;
      if (axi.m_axi_rvalid && axi.m_axi_rready && s_q.size() != 0) begin
         hs_total++; last_hs_cyc = cyc; s_beat++;
         if (s_beat == s_q[0].len) begin void'(s_q.pop_front()); s_beat = 0; end
         if (strobe_at_done && hs_total == cur_n) strobe_cyc = cyc + 2;
      end
      if (o_rd_valid && i_rd_ready) data_obs.push_back(o_rd_data);
      if (o_read_done) begin done_cnt++; done_cyc = cyc; end
   endtask

   // Issue one command and check it against the reference model.
   task automatic run_cmd(input logic [31:0] a, input int n, input int exp_nar,
                          input int exp_last_len, input bit sad, input bit busy_strobe);
      int            start, rem, idx, b;
      logic [31:0]   ea;
      clear_obs();
      cmd_addr = a; cmd_n = BT'(n); cmd_go = 1; cur_n = n; strobe_at_done = sad;
      start = cyc + 1;
      for (int k = 0; k < n * 10 + 60 && done_cnt == 0; k++) begin
         if (busy_strobe && k == 5) begin cmd_go = 1; cmd_addr = 32'h5555_0000; cmd_n = 18'd3; end
         step();
      end
      chk("done_seen", done_cnt, 1);
      for (int k = 0; k < 6; k++) step();
      chk("done_pulses", done_cnt, 1);
      chk("busy_after", o_busy, 0);
      chk("protocol_viol", viol, 0);
      chk("ar_count", ar_addr_obs.size(), exp_nar);
      if (exp_nar > 0 && ar_len_obs.size() != 0) chk("last_arlen", ar_len_obs[$], exp_last_len);
      // Model: split n beats into MBL-beat bursts from address a.
      ea = a; rem = n; idx = 0;
      while (rem > 0) begin
         b = (rem > MBL) ? MBL : rem;
         if (idx < ar_addr_obs.size()) begin
            chk("ar_addr", ar_addr_obs[idx], ea);
            chk("ar_len", ar_len_obs[idx], b - 1);
         end
         ea = ea + 32'(b * BYTES); rem -= b; idx++;
      end
      chk("beat_count", data_obs.size(), n);
      for (int k = 0; k < n && k < data_obs.size(); k++)
         chk("beat_data", data_obs[k], dfun(a + 32'(k * BYTES)));
      if (n > 0) begin
         chk("ar_latency", arv_first_cyc - start, 1);
         chk("done_latency", done_cyc - last_hs_cyc, 2);
      end else begin
         chk("zero_no_ar", arv_first_cyc, -1);
         chk("zero_done_latency", (done_cyc - start >= 1 && done_cyc - start <= 2), 1);
      end
      strobe_at_done = 0; strobe_cyc = -1;
   endtask

   typedef struct {
      logic [31:0] addr; int n; int rdy; int gap; bit arr;
      int exp_nar; int exp_last_len;
   } vec_t;
   vec_t vecs[6];

   initial begin
      vecs[0] = '{32'h1000_0000,  16, 0,  0, 0, 1, 15};
      vecs[1] = '{32'h2000_0000,  40, 0,  0, 0, 3,  7};
      vecs[2] = '{32'h1000_0400,  16, 1, 40, 0, 1, 15};
      vecs[3] = '{32'h0000_0040,   1, 2, 30, 1, 1,  0};
      vecs[4] = '{32'h4000_0000, 100, 2, 30, 1, 7,  3};
      vecs[5] = '{32'hFFFF_FFC0,  40, 0, 20, 1, 3,  7};

      rst = 1'b1; i_ctrl_read = 1'b0; i_read_addr = '0; i_num_trans = '0; i_rd_ready = 1'b0;
      axi.m_axi_arready = 1'b0; axi.m_axi_rvalid = 1'b0; axi.m_axi_rdata = '0;
      axi.m_axi_rresp = 2'b00; axi.m_axi_rlast = 1'b0;
      slave_reset(); clear_obs();
      repeat (3) step();
      rst = 1'b0;
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_read_done, 0);
      chk("rst_rd_valid", o_rd_valid, 0);
      chk("rst_arvalid", axi.m_axi_arvalid, 0);
      chk("rst_rready", axi.m_axi_rready, 0);
      chk("rst_araddr", axi.m_axi_araddr, 0);
      chk("rst_arlen", axi.m_axi_arlen, 0);
      chk("rst_rd_data", o_rd_data, 0);
      chk("arsize", axi.m_axi_arsize, 2);
      chk("arburst", axi.m_axi_arburst, 1);
      step();

      // Table vectors; vector 0 also strobes in the done cycle, vector 1
      // strobes while busy - both strobes must be ignored.
      for (int i = 0; i < 6; i++) begin
         rdy_mode = vecs[i].rdy; gap_pct = vecs[i].gap; arrdy_rand = vecs[i].arr;
         run_cmd(vecs[i].addr, vecs[i].n, vecs[i].exp_nar, vecs[i].exp_last_len, i == 0, i == 1);
      end

      // Zero-length command.
      rdy_mode = 0; gap_pct = 0; arrdy_rand = 0;
      run_cmd(32'h5000_0000, 0, 0, 0, 0, 0);

      // Reset during the third beat, then a fresh command.
      clear_obs();
      cmd_addr = 32'h6000_0000; cmd_n = 18'd16; cmd_go = 1;
      for (int k = 0; k < 200 && hs_total < 2; k++) step();
      chk("pre_rst_beats", hs_total, 2);
      rst = 1'b1;
      step();
      slave_reset();
      rst = 1'b0;
      step();
      chk("midrst_busy", o_busy, 0);
      chk("midrst_arvalid", axi.m_axi_arvalid, 0);
      chk("midrst_rready", axi.m_axi_rready, 0);
      chk("midrst_rd_valid", o_rd_valid, 0);
      chk("midrst_araddr", axi.m_axi_araddr, 0);
      chk("midrst_arlen", axi.m_axi_arlen, 0);
      chk("midrst_done", o_read_done, 0);
      run_cmd(32'h3000_0000, 16, 1, 15, 0, 0);

      // Random commands against the model.
      for (int i = 0; i < 6; i++) begin
         int n;
         logic [31:0] a;
         n = $urandom_range(1, 70);
         a = $urandom & 32'hFFFF_FFC0;
         rdy_mode = $urandom_range(0, 2); gap_pct = $urandom_range(0, 40);
         arrdy_rand = 1'($urandom_range(0, 1));
         run_cmd(a, n, (n + MBL - 1) / MBL, (n - 1) % MBL, 0, 0);
      end

`ifdef DMA_RD_ERR_CHK_EN
      rdy_mode = 0; gap_pct = 0; arrdy_rand = 0;
      inj_resp_beat = 4; inj_last_beat = 6;
      run_cmd(32'h7000_0000, 16, 1, 15, 0, 0);
      chk("err_flags", o_rd_err, 2'b11);
      inj_resp_beat = -1; inj_last_beat = -1;
      run_cmd(32'h7000_1000, 16, 1, 15, 0, 0);
      chk("err_cleared", o_rd_err, 2'b00);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
